// File: rtl/sigreplay.sv
// sigreplay: 2-entry input FIFO feeding a replay engine that emits each IQ
// sample TRATE times with a time address and correlation-block markers.
module sigreplay #(
    parameter int WIDTH = 32,
    parameter int TRATE = 30,
    parameter int TBITS = 5,
    parameter int COUNT = 256,
    parameter int CBITS = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [WIDTH-1:0] s_idata_i,
    input  logic [WIDTH-1:0] s_qdata_i,
    output logic             valid_o,
    output logic             first_o,
    output logic             last_o,
    output logic [TBITS-1:0] taddr_o,
    output logic [WIDTH-1:0] idata_o,
    output logic [WIDTH-1:0] qdata_o
);

    typedef enum logic {IDLE, REPLAY} state_t;

    localparam logic [TBITS-1:0] TLAST = TBITS'(TRATE - 1);
    localparam logic [CBITS-1:0] CLAST = CBITS'(COUNT - 1);

    state_t           state_q, state_d;
    logic [1:0]       level_q, level_d;
    logic             wrPtr_q, wrPtr_d;
    logic             rdPtr_q, rdPtr_d;
    logic [WIDTH-1:0] memI_q [2];
    logic [WIDTH-1:0] memQ_q [2];
    logic [TBITS-1:0] taddr_q, taddr_d;
    logic [CBITS-1:0] scount_q, scount_d;
    logic [WIDTH-1:0] idata_q, idata_d;
    logic [WIDTH-1:0] qdata_q, qdata_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             push;
    logic             pop;

    assign s_ready_o = (level_q != 2'd2) & reset_n;
    assign push      = s_valid_i & s_ready_o;

    assign valid_o = (state_q == REPLAY);
    assign first_o = first_q;
    assign last_o  = last_q;
    assign taddr_o = taddr_q;
    assign idata_o = idata_q;
    assign qdata_o = qdata_q;

    // Engine decides on the registered level only, so a word pushed on the
    // same edge as the final-replay decision is picked up one cycle later.
    always_comb begin
        state_d  = state_q;
        taddr_d  = taddr_q;
        scount_d = scount_q;
        idata_d  = idata_q;
        qdata_d  = qdata_q;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (level_q != 2'd0) begin
                    pop     = 1'b1;
                    state_d = REPLAY;
                end
            end
            REPLAY: begin
                if (taddr_q != TLAST) begin
                    taddr_d = taddr_q + TBITS'(1);
                end else begin
                    scount_d = (scount_q == CLAST) ? '0 : scount_q + CBITS'(1);
                    if (level_q != 2'd0) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
        if (pop) begin
            taddr_d = '0;
            idata_d = memI_q[rdPtr_q];
            qdata_d = memQ_q[rdPtr_q];
        end
        first_d = (state_d == REPLAY) & (taddr_d == '0) & (scount_d == '0);
        last_d  = (state_d == REPLAY) & (taddr_d == TLAST) & (scount_d == CLAST);

        wrPtr_d = push ? ~wrPtr_q : wrPtr_q;
        rdPtr_d = pop ? ~rdPtr_q : rdPtr_q;
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 2'd1;
        end else if (pop && !push) begin
            level_d = level_q - 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            level_q   <= 2'd0;
            wrPtr_q   <= 1'b0;
            rdPtr_q   <= 1'b0;
            memI_q[0] <= '0;
            memI_q[1] <= '0;
            memQ_q[0] <= '0;
            memQ_q[1] <= '0;
            taddr_q   <= '0;
            scount_q  <= '0;
            idata_q   <= '0;
            qdata_q   <= '0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            taddr_q  <= taddr_d;
            scount_q <= scount_d;
            idata_q  <= idata_d;
            qdata_q  <= qdata_d;
            first_q  <= first_d;
            last_q   <= last_d;
            if (push) begin
                memI_q[wrPtr_q] <= s_idata_i;
                memQ_q[wrPtr_q] <= s_qdata_i;
            end
        end
    end

endmodule

// File: tb/tb_sigreplay.sv
// Bench for sigreplay: a default-parameter instance for long-replay checks and
// a small TRATE=4/COUNT=3 instance checked beat-by-beat against a queue model.
module tb_sigreplay;

    localparam int BTRATE = 4;
    localparam int BCOUNT = 3;

    logic        clock = 1'b0;
    logic        resetN;

    logic        aValid, aReady, aOutValid, aFirst, aLast;
    logic [31:0] aI, aQ, aIdata, aQdata;
    logic [4:0]  aTaddr;

    logic        bValid, bReady, bOutValid, bFirst, bLast;
    logic [31:0] bI, bQ, bIdata, bQdata;
    logic [1:0]  bTaddr;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic [1:0]  taddr;
        logic        first;
        logic        last;
        logic [31:0] i;
        logic [31:0] q;
    } beat_t;

    beat_t expQ[$];
    int    sampleIdx   = 0;
    int    runsDone    = 0;
    int    runLen      = 0;
    int    lastRunLen  = 0;
    int    firstPulses = 0;
    int    lastPulses  = 0;
    logic  prevValid   = 1'b0;

    sigreplay uA (
        .clock(clock), .reset_n(resetN),
        .s_valid_i(aValid), .s_ready_o(aReady), .s_idata_i(aI), .s_qdata_i(aQ),
        .valid_o(aOutValid), .first_o(aFirst), .last_o(aLast),
        .taddr_o(aTaddr), .idata_o(aIdata), .qdata_o(aQdata)
    );

    sigreplay #(.WIDTH(32), .TRATE(BTRATE), .TBITS(2), .COUNT(BCOUNT), .CBITS(2)) uB (
        .clock(clock), .reset_n(resetN),
        .s_valid_i(bValid), .s_ready_o(bReady), .s_idata_i(bI), .s_qdata_i(bQ),
        .valid_o(bOutValid), .first_o(bFirst), .last_o(bLast),
        .taddr_o(bTaddr), .idata_o(bIdata), .qdata_o(bQdata)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] i, input logic [31:0] q);
        bValid = valid;
        bI     = i;
        bQ     = q;
        @(posedge clock);
        #1;
    endtask

    // Every accepted word becomes TRATE expected beats; block position comes
    // from the running sample index modulo COUNT.
    task automatic monitorB();
        beat_t want;
        beat_t b;
        forever begin
            @(negedge clock);
            if (bOutValid) begin
                if (bTaddr != 2'd0) checkOutput("B contiguous replay", 32'(prevValid), 1);
                if (expQ.size() == 0) begin
                    checkOutput("B spurious valid", 32'(bOutValid), 0);
                end else begin
                    want = expQ.pop_front();
                    checkOutput("B taddr", 32'(bTaddr), 32'(want.taddr));
                    checkOutput("B first", 32'(bFirst), 32'(want.first));
                    checkOutput("B last", 32'(bLast), 32'(want.last));
                    checkOutput("B idata", bIdata, want.i);
                    checkOutput("B qdata", bQdata, want.q);
                end
                runLen++;
            end else if (prevValid) begin
                runsDone++;
                lastRunLen = runLen;
                runLen = 0;
            end
            if (bFirst) firstPulses++;
            if (bLast) lastPulses++;
            prevValid = bOutValid;
            if (!resetN) begin
                expQ.delete();
                sampleIdx = 0;
            end else if (bValid && bReady) begin
                for (int t = 0; t < BTRATE; t++) begin
                    b.taddr = 2'(t);
                    b.first = (t == 0) && (sampleIdx == 0);
                    b.last  = (t == BTRATE - 1) && (sampleIdx == BCOUNT - 1);
                    b.i     = bI;
                    b.q     = bQ;
                    expQ.push_back(b);
                end
                sampleIdx = (sampleIdx + 1) % BCOUNT;
            end
        end
    endtask

    initial begin
        int f0, l0, r0, violations, highs, found, sawValid;
        logic [31:0] dataCnt;
        logic readyHist [40];

        resetN = 1'b0;
        aValid = 1'b0; aI = '0; aQ = '0;
        bValid = 1'b0; bI = '0; bQ = '0;
        fork
            monitorB();
        join_none
        repeat (2) @(posedge clock);
        #1;

        $display("[TB] reset state");
        checkOutput("A ready in reset", 32'(aReady), 0);
        checkOutput("B ready in reset", 32'(bReady), 0);
        checkOutput("A valid reset", 32'(aOutValid), 0);
        checkOutput("A first reset", 32'(aFirst), 0);
        checkOutput("A last reset", 32'(aLast), 0);
        checkOutput("A taddr reset", 32'(aTaddr), 0);
        checkOutput("A idata reset", aIdata, 0);
        checkOutput("A qdata reset", aQdata, 0);
        resetN = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("A ready after reset", 32'(aReady), 1);

        $display("[TB] single word, default parameters");
        aValid = 1'b1; aI = 32'hA5A5A5A5; aQ = 32'h5A5A5A5A;
        @(posedge clock);
        #1;
        aValid = 1'b0;
        checkOutput("A valid after push edge", 32'(aOutValid), 0);
        for (int c = 0; c < 30; c++) begin
            @(posedge clock);
            #1;
            checkOutput("A single valid", 32'(aOutValid), 1);
            checkOutput("A single taddr", 32'(aTaddr), c);
            checkOutput("A single idata", aIdata, 32'hA5A5A5A5);
            checkOutput("A single qdata", aQdata, 32'h5A5A5A5A);
            checkOutput("A single first", 32'(aFirst), (c == 0) ? 1 : 0);
            checkOutput("A single last", 32'(aLast), 0);
        end
        @(posedge clock);
        #1;
        checkOutput("A single valid ends", 32'(aOutValid), 0);
        checkOutput("A single last after", 32'(aLast), 0);

        $display("[TB] back-to-back, TRATE=4 COUNT=3");
        f0 = firstPulses; l0 = lastPulses; r0 = runsDone;
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b1, 32'(k), ~32'(k));
            repeat (3) applyStimulus(1'b0, '0, '0);
        end
        repeat (10) applyStimulus(1'b0, '0, '0);
        checkOutput("B b2b run count", runsDone - r0, 1);
        checkOutput("B b2b run length", lastRunLen, 24);
        checkOutput("B b2b first pulses", firstPulses - f0, 2);
        checkOutput("B b2b last pulses", lastPulses - l0, 2);

        $display("[TB] backpressure");
        resetN = 1'b0;
        applyStimulus(1'b0, '0, '0);
        resetN = 1'b1;
        dataCnt = 32'd1000;
        for (int c = 0; c < 40; c++) begin
            readyHist[c] = bReady;
            applyStimulus(1'b1, dataCnt, ~dataCnt);
            if (readyHist[c]) dataCnt = dataCnt + 32'd1;
        end
        bValid = 1'b0;
        checkOutput("B ready drops when full", 32'(readyHist[3]), 0);
        checkOutput("B ready returns after pop", 32'(readyHist[6]), 1);
        violations = 0;
        for (int c = 4; c <= 36; c++) begin
            highs = 0;
            for (int j = 0; j < 4; j++) if (readyHist[c + j]) highs++;
            if (highs != 1) violations++;
        end
        checkOutput("B ready once per replay", violations, 0);
        repeat (60) applyStimulus(1'b0, '0, '0);
        checkOutput("B backpressure drained", expQ.size(), 0);

        $display("[TB] starvation gap");
        resetN = 1'b0;
        applyStimulus(1'b0, '0, '0);
        resetN = 1'b1;
        f0 = firstPulses; r0 = runsDone;
        applyStimulus(1'b1, 32'h11, 32'h22);
        repeat (10) applyStimulus(1'b0, '0, '0);
        applyStimulus(1'b1, 32'h33, 32'h44);
        repeat (10) applyStimulus(1'b0, '0, '0);
        checkOutput("B gap run count", runsDone - r0, 2);
        checkOutput("B gap first pulses", firstPulses - f0, 1);

        $display("[TB] reset mid-replay");
        aValid = 1'b1; aI = 32'h01010101; aQ = 32'h10101010;
        @(posedge clock);
        #1;
        aI = 32'h02020202; aQ = 32'h20202020;
        @(posedge clock);
        #1;
        aValid = 1'b0;
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            if (aOutValid && aTaddr == 5'd12 && aIdata == 32'h02020202) found = 1;
            else begin
                @(posedge clock);
                #1;
            end
        end
        checkOutput("A reached second sample taddr 12", found, 1);
        resetN = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("A valid after mid reset", 32'(aOutValid), 0);
        checkOutput("A first after mid reset", 32'(aFirst), 0);
        checkOutput("A last after mid reset", 32'(aLast), 0);
        checkOutput("A taddr after mid reset", 32'(aTaddr), 0);
        checkOutput("A idata after mid reset", aIdata, 0);
        checkOutput("A qdata after mid reset", aQdata, 0);
        checkOutput("A ready during reset", 32'(aReady), 0);
        resetN = 1'b1;
        sawValid = 0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (aOutValid) sawValid = 1;
        end
        checkOutput("A discarded sample stays gone", sawValid, 0);
        aValid = 1'b1; aI = 32'h03030303; aQ = 32'h30303030;
        @(posedge clock);
        #1;
        aValid = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("A post-reset valid", 32'(aOutValid), 1);
        checkOutput("A post-reset first", 32'(aFirst), 1);
        checkOutput("A post-reset taddr", 32'(aTaddr), 0);
        checkOutput("A post-reset idata", aIdata, 32'h03030303);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 199) == 0) resetN = 1'b0;
            applyStimulus(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0, $urandom, $urandom);
            resetN = 1'b1;
        end
        repeat (40) applyStimulus(1'b0, '0, '0);
        checkOutput("B random drained", expQ.size(), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
